// File: rtl/eth_pkg.sv
// Shared Ethernet framing definitions for the frame transmitter and receiver.
package eth_pkg;

  typedef logic [47:0] mac_addr_t;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StPreamble,
    StMacDst,
    StMacSrc,
    StPlLen,
    StPl,
    StFcs,
    StDone
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int unsigned PREAMBLE_LEN = 8;
  localparam int unsigned MAC_LEN      = 6;
  localparam int unsigned LEN_LEN      = 2;
  localparam int unsigned FCS_LEN      = 4;

  // Byte idx of a MAC address, byte 0 being the least significant.
  function automatic logic [7:0] mac_byte(input mac_addr_t mac, input logic [2:0] idx);
    return 8'(mac >> {idx, 3'b000});
  endfunction

endpackage

// File: rtl/eth_frame_tx_if.sv
// Request, payload and byte-stream signals of the frame transmitter.
// TX_ERR_INJECT_EN adds the inject_fcs_err request field.
interface eth_frame_tx_if;
  import eth_pkg::*;

  logic        req;
  mac_addr_t   dest_mac;
  logic [15:0] length;
  logic        idle;
  logic [7:0]  pl_data;
  logic        pl_vld;
  logic        pl_rdy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_vld;
  logic        done;
  logic        err;
`ifdef TX_ERR_INJECT_EN
  logic        inject_fcs_err;

  modport master (
    output req, dest_mac, length, pl_data, pl_vld, inject_fcs_err,
    input  idle, pl_rdy, tx_data, tx_start, tx_vld, done, err
  );
  modport slave (
    input  req, dest_mac, length, pl_data, pl_vld, inject_fcs_err,
    output idle, pl_rdy, tx_data, tx_start, tx_vld, done, err
  );
`else
  modport master (
    output req, dest_mac, length, pl_data, pl_vld,
    input  idle, pl_rdy, tx_data, tx_start, tx_vld, done, err
  );
  modport slave (
    input  req, dest_mac, length, pl_data, pl_vld,
    output idle, pl_rdy, tx_data, tx_start, tx_vld, done, err
  );
`endif
endinterface

// File: rtl/eth_lrc_acc.sv
// 8-bit wrap-around byte accumulator (clear/add/hold) with its two's-complement negation.
module eth_lrc_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_add,
  input  logic [7:0] i_byte,
  output logic [7:0] o_sum,
  output logic [7:0] o_neg
);

  logic [7:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_byte;
    end
  end

  assign o_sum = r_sum;
  assign o_neg = (~r_sum) + 8'd1;

endmodule

// File: rtl/eth_frame_tx.sv
// Ethernet-style frame transmitter: preamble, SFD, MACs, length, payload, 4x LRC-based FCS.
// TX_ERR_INJECT_EN enables bit-inverted FCS bytes on request.
module eth_frame_tx
  import eth_pkg::*;
#(
  parameter mac_addr_t   SRC_MAC_ADDR    = 48'h00_0a_95_9d_68_17,
  parameter int unsigned MAX_PAYLOAD_LEN = 1500
) (
  input logic          clk,
  input logic          rst,
  eth_frame_tx_if.slave bus
);

  localparam logic [15:0] PREAMBLE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] MAC_LAST      = 16'(MAC_LEN - 1);
  localparam logic [15:0] LEN_LAST      = 16'(LEN_LEN - 1);
  localparam logic [15:0] FCS_LAST      = 16'(FCS_LEN - 1);

  state_t      r_state;
  state_t      w_state_d;
  logic [15:0] r_cnt;
  mac_addr_t   r_dest_mac;
  logic [15:0] r_length;
  logic        r_err_flag;
  logic        r_inject;

  logic       w_too_long;
  logic [7:0] w_tx_data;
  logic       w_tx_vld;
  logic       w_pl_rdy;
  logic       w_lrc_add;
  logic [7:0] w_lrc_sum;
  logic [7:0] w_lrc_neg;
  logic [7:0] w_fcs_byte;

  assign w_too_long = bus.length > 16'(MAX_PAYLOAD_LEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_dest_mac <= '0;
      r_length   <= '0;
      r_err_flag <= 1'b0;
      r_inject   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= (w_state_d != r_state) ? 16'd0 : r_cnt + 16'd1;
      if (r_state == StIdle) begin
        // Underrun flag is dropped while idle; a reject is the only way to leave with it set.
        r_err_flag <= bus.req && w_too_long;
        if (bus.req) begin
          r_dest_mac <= bus.dest_mac;
          r_length   <= bus.length;
`ifdef TX_ERR_INJECT_EN
          r_inject   <= bus.inject_fcs_err;
`else
          r_inject   <= 1'b0;
`endif
        end
      end else if (r_state == StPl && !bus.pl_vld) begin
        r_err_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:     if (bus.req) w_state_d = w_too_long ? StDone : StStart;
      StStart:    w_state_d = StPreamble;
      StPreamble: if (r_cnt == PREAMBLE_LAST) w_state_d = StMacDst;
      StMacDst:   if (r_cnt == MAC_LAST) w_state_d = StMacSrc;
      StMacSrc:   if (r_cnt == MAC_LAST) w_state_d = StPlLen;
      StPlLen:    if (r_cnt == LEN_LAST) w_state_d = (r_length == 16'd0) ? StFcs : StPl;
      StPl:       if (r_cnt == r_length - 16'd1) w_state_d = StFcs;
      StFcs:      if (r_cnt == FCS_LAST) w_state_d = StDone;
      StDone:     w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  assign w_fcs_byte = w_lrc_neg ^ {8{r_inject}};

  always_comb begin
    w_tx_data = 8'h00;
    w_tx_vld  = 1'b0;
    w_pl_rdy  = 1'b0;
    w_lrc_add = 1'b0;
    unique case (r_state)
      StPreamble: begin
        w_tx_vld  = 1'b1;
        w_tx_data = (r_cnt == PREAMBLE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
      end
      StMacDst: begin
        w_tx_vld  = 1'b1;
        w_lrc_add = 1'b1;
        w_tx_data = mac_byte(r_dest_mac, r_cnt[2:0]);
      end
      StMacSrc: begin
        w_tx_vld  = 1'b1;
        w_lrc_add = 1'b1;
        w_tx_data = mac_byte(SRC_MAC_ADDR, r_cnt[2:0]);
      end
      StPlLen: begin
        w_tx_vld  = 1'b1;
        w_lrc_add = 1'b1;
        w_tx_data = r_cnt[0] ? r_length[7:0] : r_length[15:8];
      end
      StPl: begin
        w_tx_vld  = 1'b1;
        w_lrc_add = 1'b1;
        w_pl_rdy  = 1'b1;
        w_tx_data = bus.pl_vld ? bus.pl_data : 8'h00;
      end
      StFcs: begin
        w_tx_vld  = 1'b1;
        w_tx_data = w_fcs_byte;
      end
      default: ;
    endcase
  end

  eth_lrc_acc u_lrc (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == StIdle),
    .i_add   (w_lrc_add),
    .i_byte  (w_tx_data),
    .o_sum   (w_lrc_sum),
    .o_neg   (w_lrc_neg)
  );

  assign bus.idle     = (r_state == StIdle);
  assign bus.tx_start = (r_state == StStart);
  assign bus.done     = (r_state == StDone);
  assign bus.err      = (r_state == StDone) && r_err_flag;
  assign bus.tx_data  = w_tx_data;
  assign bus.tx_vld   = w_tx_vld;
  assign bus.pl_rdy   = w_pl_rdy;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Self-checking bench for eth_frame_tx against a byte-list frame model.
module tb_eth_frame_tx;
  import eth_pkg::*;

  localparam mac_addr_t SRC    = 48'h00_0a_95_9d_68_17;
  localparam int        MAXLEN = 1500;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_frame_tx_if bus ();

  eth_frame_tx #(
    .SRC_MAC_ADDR    (SRC),
    .MAX_PAYLOAD_LEN (MAXLEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit g_inject = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request; model builds the frame as a byte list from the framing rules.
  task automatic run_frame(input mac_addr_t dest, input int len, input int gap_slot,
                           input bit rand_gaps, input bit busy_req);
    logic [7:0] pl[$];
    bit         vld[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int   sum = 0;
    bit   exp_err = 1'b0;
    int   slot = 0;
    int   start_cyc = -1;
    int   first_cyc = -1;
    int   done_cyc = -1;
    logic err_seen = 1'b0;
    int   zero_bad = 0;
    int   frame_len;
    logic [7:0] fcs;

    for (int i = 0; i < len; i++) begin
      pl.push_back(8'($urandom));
      vld.push_back(!(i == gap_slot) && !(rand_gaps && $urandom_range(0, 5) == 0));
    end
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) exp_q.push_back(dest[i*8 +: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(SRC[i*8 +: 8]);
    exp_q.push_back(8'(len >> 8));
    exp_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(vld[i] ? pl[i] : 8'h00);
      if (!vld[i]) exp_err = 1'b1;
    end
    for (int i = 8; i < exp_q.size(); i++) sum += int'(exp_q[i]);
    fcs = 8'((256 - (sum % 256)) % 256);
    if (g_inject) fcs = ~fcs;
    for (int i = 0; i < 4; i++) exp_q.push_back(fcs);
    frame_len = exp_q.size();

    @(negedge clk);
    check("idle_before_req", bus.idle, 1'b1);
    bus.req      = 1'b1;
    bus.dest_mac = dest;
    bus.length   = 16'(len);
`ifdef TX_ERR_INJECT_EN
    bus.inject_fcs_err = g_inject;
`endif
    @(posedge clk);
    @(negedge clk);
    for (int cyc = 0; cyc < len + 60; cyc++) begin
      bus.req = busy_req && cyc < 3;
      if (busy_req) bus.length = 16'd7;
      bus.pl_vld  = 1'b0;
      bus.pl_data = 8'($urandom);
      if (bus.pl_rdy) begin
        if (slot < len) begin
          bus.pl_vld = vld[slot];
          if (vld[slot]) bus.pl_data = pl[slot];
        end
        slot++;
      end
      #1;
      if (bus.tx_start && start_cyc < 0) start_cyc = cyc;
      if (bus.tx_vld) begin
        got_q.push_back(bus.tx_data);
        if (first_cyc < 0) first_cyc = cyc;
      end else if (bus.tx_data !== 8'h00) begin
        zero_bad++;
      end
      if (bus.done) begin
        done_cyc = cyc;
        err_seen = bus.err;
        break;
      end
      @(negedge clk);
    end
    bus.req    = 1'b0;
    bus.pl_vld = 1'b0;

    check("tx_start_cycle", start_cyc, 0);
    check("first_byte_cycle", first_cyc, 1);
    check("done_cycle", done_cyc, frame_len + 1);
    check("frame_bytes", got_q.size(), frame_len);
    for (int i = 0; i < frame_len && i < got_q.size(); i++)
      check($sformatf("byte[%0d]", i), got_q[i], exp_q[i]);
    check("err_flag", err_seen, exp_err);
    check("pl_rdy_slots", slot, len);
    check("idle_data_zero", zero_bad, 0);
  endtask

  initial begin
    int   done_cyc;
    logic err_seen;
    bit   vld_seen;
    int   rdy_cnt;
    mac_addr_t d;

    rst          = 1'b1;
    bus.req      = 1'b0;
    bus.dest_mac = '0;
    bus.length   = '0;
    bus.pl_data  = '0;
    bus.pl_vld   = 1'b0;
`ifdef TX_ERR_INJECT_EN
    bus.inject_fcs_err = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_idle", bus.idle, 1'b1);
    check("rst_tx_vld", bus.tx_vld, 1'b0);
    check("rst_tx_start", bus.tx_start, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_pl_rdy", bus.pl_rdy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    rst = 1'b0;

    // Directed frame from the datasheet example, then boundary lengths and underruns.
    run_frame(48'h00_0a_95_9d_68_16, 3, -1, 1'b0, 1'b0);
    run_frame({16'($urandom), 32'($urandom)}, 0, -1, 1'b0, 1'b0);
    run_frame({16'($urandom), 32'($urandom)}, 4, 1, 1'b0, 1'b0);
    run_frame({16'($urandom), 32'($urandom)}, 1, -1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++)
      run_frame({16'($urandom), 32'($urandom)}, int'($urandom_range(1, 40)), -1,
                1'b1, 1'b0);
    run_frame({16'($urandom), 32'($urandom)}, 64, -1, 1'b0, 1'b0);
    run_frame({16'($urandom), 32'($urandom)}, MAXLEN, -1, 1'b0, 1'b0);

    // Oversized request is rejected without any stream activity.
    @(negedge clk);
    bus.req    = 1'b1;
    bus.length = 16'(MAXLEN + 1);
    @(posedge clk);
    @(negedge clk);
    bus.req  = 1'b0;
    done_cyc = -1;
    err_seen = 1'b0;
    vld_seen = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      if (bus.tx_vld || bus.tx_start) vld_seen = 1'b1;
      if (bus.done && done_cyc < 0) begin
        done_cyc = cyc;
        err_seen = bus.err;
      end
      @(negedge clk);
    end
    check("reject_done_cycle", done_cyc, 0);
    check("reject_err", err_seen, 1'b1);
    check("reject_no_stream", vld_seen, 1'b0);

    // Reset in the middle of the payload aborts the frame without a done pulse.
    @(negedge clk);
    d            = {16'($urandom), 32'($urandom)};
    bus.req      = 1'b1;
    bus.dest_mac = d;
    bus.length   = 16'd6;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    rdy_cnt = 0;
    for (int cyc = 0; cyc < 60 && rdy_cnt < 2; cyc++) begin
      bus.pl_vld  = bus.pl_rdy;
      bus.pl_data = 8'($urandom);
      if (bus.pl_rdy) rdy_cnt++;
      if (rdy_cnt < 2) @(negedge clk);
    end
    check("rst_mid_reached_pl2", rdy_cnt, 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("abort_idle", bus.idle, 1'b1);
    check("abort_tx_vld", bus.tx_vld, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_pl_rdy", bus.pl_rdy, 1'b0);
    rst        = 1'b0;
    bus.pl_vld = 1'b0;
    vld_seen   = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (bus.done || bus.tx_vld) vld_seen = 1'b1;
    end
    check("abort_quiet", vld_seen, 1'b0);
    run_frame({16'($urandom), 32'($urandom)}, 5, -1, 1'b0, 1'b0);

`ifdef TX_ERR_INJECT_EN
    g_inject = 1'b1;
    run_frame({16'($urandom), 32'($urandom)}, 8, -1, 1'b0, 1'b0);
    g_inject = 1'b0;
    run_frame({16'($urandom), 32'($urandom)}, 8, -1, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
